// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard mode presets and counter-width sizing.
package vga_pkg;

    // 640x480@60, negative/negative sync
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam int VGA640_HS_POL   = 0;
    localparam int VGA640_VS_POL   = 0;

    // 800x600@60, positive/positive sync
    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 40;
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BP     = 88;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 1;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BP     = 23;
    localparam int VGA800_HS_POL   = 1;
    localparam int VGA800_VS_POL   = 1;

    // 1024x768@60, negative/negative sync
    localparam int VGA1024_H_ACTIVE = 1024;
    localparam int VGA1024_H_FP     = 24;
    localparam int VGA1024_H_SYNC   = 136;
    localparam int VGA1024_H_BP     = 160;
    localparam int VGA1024_V_ACTIVE = 768;
    localparam int VGA1024_V_FP     = 3;
    localparam int VGA1024_V_SYNC   = 6;
    localparam int VGA1024_V_BP     = 29;
    localparam int VGA1024_HS_POL   = 0;
    localparam int VGA1024_VS_POL   = 0;

    // Smallest width w with 2**w > total.
    function automatic int cnt_width(input int total);
        for (int w = 1; w < 31; w++) begin
            if ((total >> w) == 0) return w;
        end
        return 31;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// Generic raster axis: wrap counter plus registered blank/sync compares, all
// computed from the next count so they stay aligned with the count they describe.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 800,
    parameter int FP     = 40,
    parameter int SYNC   = 128,
    parameter int BP     = 88,
    parameter int POL    = 1,
    parameter int CNT_W  = 11
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             adv,
    output logic [CNT_W-1:0] count,
    output logic             blnk,
    output logic             sync,
    output logic             wrap,
    output logic             active_next
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_C = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SS_C     = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SE_C     = CNT_W'(ACTIVE + FP + SYNC);
    localparam logic             POL_B    = (POL != 0);

    if (ACTIVE < 1 || SYNC < 1 || FP < 0 || BP < 0) begin : g_bad_widths
        $error("vga_axis_counter: active and sync widths must be >= 1, porches >= 0");
    end
    if (CNT_W < cnt_width(TOTAL)) begin : g_bad_cnt_w
        $error("vga_axis_counter: CNT_W too narrow for the axis total");
    end

    logic [CNT_W-1:0] count_reg, count_next;
    logic             blnk_reg, sync_reg;

    assign wrap = (count_reg == LAST_C);

    always_comb begin
        count_next = count_reg;
        if (adv) begin
            count_next = wrap ? '0 : count_reg + 1'b1;
        end
    end

    assign active_next = (count_next < ACTIVE_C);

    always_ff @(posedge pclk) begin
        if (rst) begin
            count_reg <= '0;
            blnk_reg  <= 1'b0;
            sync_reg  <= ~POL_B;
        end else begin
            count_reg <= count_next;
            blnk_reg  <= (count_next >= ACTIVE_C);
            sync_reg  <= (count_next >= SS_C && count_next < SE_C) ? POL_B : ~POL_B;
        end
    end

    assign count = count_reg;
    assign blnk  = blnk_reg;
    assign sync  = sync_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA800_H_ACTIVE,
    parameter int H_FP     = VGA800_H_FP,
    parameter int H_SYNC   = VGA800_H_SYNC,
    parameter int H_BP     = VGA800_H_BP,
    parameter int V_ACTIVE = VGA800_V_ACTIVE,
    parameter int V_FP     = VGA800_V_FP,
    parameter int V_SYNC   = VGA800_V_SYNC,
    parameter int V_BP     = VGA800_V_BP,
    parameter int HS_POL   = VGA800_HS_POL,
    parameter int VS_POL   = VGA800_VS_POL,
`ifdef VGA_TIMING_FRAME_CNT_EN
    parameter int FRAME_CNT_W = 16,
`endif
    parameter int CNT_W    = 11
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             de,
    output logic             line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [FRAME_CNT_W-1:0] frame_cnt,
`endif
    output logic             frame_start
);

    logic h_wrap, v_wrap, h_act_next, v_act_next;
    logic de_reg, line_start_reg, frame_start_reg;
    logic v_adv;

    assign v_adv = ce & h_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .POL(HS_POL), .CNT_W(CNT_W)
    ) u_h (
        .pclk(pclk), .rst(rst), .adv(ce),
        .count(hcount), .blnk(hblnk), .sync(hsync),
        .wrap(h_wrap), .active_next(h_act_next)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .POL(VS_POL), .CNT_W(CNT_W)
    ) u_v (
        .pclk(pclk), .rst(rst), .adv(v_adv),
        .count(vcount), .blnk(vblnk), .sync(vsync),
        .wrap(v_wrap), .active_next(v_act_next)
    );

    // de has its own register so it can read 0 out of reset while (0,0) is active.
    always_ff @(posedge pclk) begin
        if (rst) begin
            de_reg          <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            if (ce) begin
                de_reg <= h_act_next & v_act_next;
            end
            line_start_reg  <= ce & h_wrap;
            frame_start_reg <= ce & h_wrap & v_wrap;
        end
    end

    assign de          = de_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_reg;

    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_cnt_reg <= '0;
        end else if (ce & h_wrap & v_wrap) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`else
`endif

endmodule
